// File: rtl/vend_dispenser_if.sv
// Selection handshake between the vend controller (master) and the dispenser (slave).
interface vend_dispenser_if;
    logic [2:0] coffee_select;
    logic [2:0] change_tokens;
    logic       dispense_done;
    logic       busy;

    modport master (
        output coffee_select,
        output change_tokens,
        input  dispense_done,
        input  busy
    );

    modport slave (
        input  coffee_select,
        input  change_tokens,
        output dispense_done,
        output busy
    );
endinterface

// File: rtl/vend_dispenser.sv
// Dispense-side responder: brews, adds flavour, pays back change tokens, then pulses done.
// All outputs are registered decodes of the next state; nothing combinational reaches a pin.
module vend_dispenser #(
    parameter int unsigned BREW_CYCLES        = 16,
    parameter int unsigned FLAVOUR_CYCLES     = 8,
    parameter int unsigned TOKEN_PULSE_CYCLES = 4,
    parameter int unsigned TOKEN_GAP_CYCLES   = 2
) (
    input  logic            clk,
    input  logic            reset,
    vend_dispenser_if.slave ctrl,
    input  logic            cup_present,
    output logic            water_pump,
    output logic            hazel_pump,
    output logic            coconut_pump,
    output logic            token_out
);

    typedef enum logic [2:0] {
        StWaitClear,
        StIdle,
        StBrew,
        StFlavour,
        StPayPulse,
        StPayGap,
        StDone
    } state_e;

    localparam logic [15:0] BrewLast    = 16'(BREW_CYCLES - 1);
    localparam logic [15:0] FlavourLast = 16'(FLAVOUR_CYCLES - 1);
    localparam logic [15:0] PulseLast   = 16'(TOKEN_PULSE_CYCLES - 1);
    localparam logic [15:0] GapLast     = 16'(TOKEN_GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  sel_q;
    logic [2:0]  chg_q;
    logic [15:0] cnt_q;
    logic        cnt_en;
    logic        water_q, hazel_q, coconut_q, token_q, done_q, busy_q;
    logic        flavour_on;

    assign flavour_on = hazel_q | coconut_q;

    // A pump cycle only counts when the pump was actually on during it.
    always_comb begin
        state_d = state_q;
        cnt_en  = 1'b0;
        unique case (state_q)
            StWaitClear: begin
                if (ctrl.coffee_select == 3'd0) state_d = StIdle;
            end
            StIdle: begin
                if (ctrl.coffee_select inside {3'd1, 3'd2, 3'd3}) state_d = StBrew;
            end
            StBrew: begin
                cnt_en = water_q;
                if (water_q && cnt_q == BrewLast) begin
                    if (sel_q != 3'd1)       state_d = StFlavour;
                    else if (chg_q == 3'd0)  state_d = StDone;
                    else                     state_d = StPayPulse;
                end
            end
            StFlavour: begin
                cnt_en = flavour_on;
                if (flavour_on && cnt_q == FlavourLast) begin
                    state_d = (chg_q == 3'd0) ? StDone : StPayPulse;
                end
            end
            StPayPulse: begin
                cnt_en = 1'b1;
                if (cnt_q == PulseLast) state_d = StPayGap;
            end
            StPayGap: begin
                cnt_en = 1'b1;
                if (cnt_q == GapLast) state_d = (chg_q == 3'd1) ? StDone : StPayPulse;
            end
            StDone: begin
                state_d = StWaitClear;
            end
            default: begin
                state_d = StWaitClear;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StWaitClear;
            sel_q     <= 3'd0;
            chg_q     <= 3'd0;
            cnt_q     <= 16'd0;
            water_q   <= 1'b0;
            hazel_q   <= 1'b0;
            coconut_q <= 1'b0;
            token_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && state_d == StBrew) begin
                sel_q <= ctrl.coffee_select;
                chg_q <= ctrl.change_tokens;
            end else if (state_q == StPayGap && state_d != StPayGap) begin
                chg_q <= chg_q - 3'd1;
            end
            if (state_d != state_q) cnt_q <= 16'd0;
            else                    cnt_q <= cnt_q + {15'd0, cnt_en};
            water_q   <= (state_d == StBrew) && cup_present;
            hazel_q   <= (state_d == StFlavour) && (sel_q == 3'd2) && cup_present;
            coconut_q <= (state_d == StFlavour) && (sel_q == 3'd3) && cup_present;
            token_q   <= (state_d == StPayPulse);
            done_q    <= (state_d == StDone);
            busy_q    <= state_d inside {StBrew, StFlavour, StPayPulse, StPayGap, StDone};
        end
    end

    assign water_pump         = water_q;
    assign hazel_pump         = hazel_q;
    assign coconut_pump       = coconut_q;
    assign token_out          = token_q;
    assign ctrl.dispense_done = done_q;
    assign ctrl.busy          = busy_q;

endmodule
